// File: rtl/fifo_ctrl_80x8.sv
// Pointer/flag controller wrapping an external single-clock 80x8 dual-port RAM
// into a synchronous FIFO with registered read data and occupancy flags.
module fifo_ctrl_80x8 #(
    parameter int unsigned DEPTH    = 80,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned AW       = 7,
    parameter int unsigned CW       = 7,
    parameter int unsigned AF_LEVEL = 76,
    parameter int unsigned AE_LEVEL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld,
    output logic             wrt_sig,
    output logic [AW-1:0]    addr_w,
    output logic [AW-1:0]    addr_r,
    output logic [WIDTH-1:0] din_ram,
    input  logic [WIDTH-1:0] dout_ram,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic             udf
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_acc;
    logic          rd_acc;

    // Flag decode and request arbitration on the pre-edge state
    always_comb begin
        full         = (count == CW'(DEPTH));
        empty        = (count == '0);
        almost_full  = (count >= CW'(AF_LEVEL));
        almost_empty = (count <= CW'(AE_LEVEL));
        wr_acc       = wr_req & ~full & ~clr;
        rd_acc       = rd_req & ~empty & ~clr;
        // Gate with rst_n so the RAM never sees a strobe while held in reset
        wrt_sig      = wr_acc & rst_n;
        addr_w       = wr_ptr;
        addr_r       = rd_ptr;
        din_ram      = wr_data;
    end

    // Write and read pointers, wrapping DEPTH-1 -> 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Occupancy counter; simultaneous accept leaves it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wr_acc && !rd_acc) begin
            count <= count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count <= count - 1'b1;
        end
    end

    // Registered read data with a one-cycle valid pulse; data holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_acc;
            if (rd_acc) rd_data <= dout_ram;
        end
    end

    // Sticky overflow/underflow, cleared only by reset or clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr_req && full)  ovf <= 1'b1;
            if (rd_req && empty) udf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_80x8.sv
// Scoreboard bench for fifo_ctrl_80x8 with a behavioural RAM and a queue-based
// reference FIFO; a separate monitor pops expected read data on rd_vld.
module tb_fifo_ctrl_80x8;

    localparam int DEPTH = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_req = 1'b0;
    logic [7:0] rd_data;
    logic       rd_vld;
    logic       wrt_sig;
    logic [6:0] addr_w;
    logic [6:0] addr_r;
    logic [7:0] din_ram;
    logic [7:0] dout_ram;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [6:0] count;
    logic       ovf;
    logic       udf;

    fifo_ctrl_80x8 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .rd_vld       (rd_vld),
        .wrt_sig      (wrt_sig),
        .addr_w       (addr_w),
        .addr_r       (addr_r),
        .din_ram      (din_ram),
        .dout_ram     (dout_ram),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .ovf          (ovf),
        .udf          (udf)
    );

    always #5 clk = ~clk;

    // Behavioural 80x8 RAM: synchronous write, combinational read
    logic [7:0] ram [DEPTH];
    always @(posedge clk) if (wrt_sig) ram[addr_w] <= din_ram;
    assign dout_ram = ram[addr_r];

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int  m_wptr = 0;
    int  m_rptr = 0;
    bit  m_ovf = 0;
    bit  m_udf = 0;
    bit  vld_exp = 0;
    int  vectors = 0;
    int  miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_wptr = 0;
        m_rptr = 0;
        m_ovf = 0;
        m_udf = 0;
        vld_exp = 0;
    endtask

    task automatic chk_state();
        int n;
        n = mq.size();
        chk("count", int'(count), n);
        chk("empty", int'(empty), int'(n == 0));
        chk("full", int'(full), int'(n == DEPTH));
        chk("almost_full", int'(almost_full), int'(n >= 76));
        chk("almost_empty", int'(almost_empty), int'(n <= 4));
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("udf", int'(udf), int'(m_udf));
        chk("addr_w", int'(addr_w), m_wptr);
        chk("addr_r", int'(addr_r), m_rptr);
    endtask

    // One clock: drive inputs, check pre-edge outputs, clock, update model
    task automatic step(input bit wr, input bit rd, input logic [7:0] d, input bit c);
        bit wacc;
        bit racc;
        bit was_full;
        bit was_empty;
        wr_req = wr;
        rd_req = rd;
        wr_data = d;
        clr = c;
        #1;
        chk_state();
        was_full = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        wacc = wr && !c && !was_full;
        racc = rd && !c && !was_empty;
        chk("wrt_sig", int'(wrt_sig), int'(wacc));
        chk("din_ram", int'(din_ram), int'(d));
        @(posedge clk);
        if (c) begin
            mq.delete();
            m_wptr = 0;
            m_rptr = 0;
            m_ovf = 0;
            m_udf = 0;
        end else begin
            if (wr && was_full) m_ovf = 1;
            if (rd && was_empty) m_udf = 1;
            if (racc) begin
                exp_q.push_back(mq.pop_front());
                m_rptr = (m_rptr + 1) % DEPTH;
            end
            if (wacc) begin
                mq.push_back(d);
                m_wptr = (m_wptr + 1) % DEPTH;
            end
        end
        vld_exp = racc;
        #2;
    endtask

    // Monitor: rd_vld must match the scoreboard, and data must come in order
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rd_vld", int'(rd_vld), int'(vld_exp));
            if (rd_vld) begin
                if (exp_q.size() == 0) begin
                    chk("rd_data_unexpected", 1, 0);
                end else begin
                    chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_vld", int'(rd_vld), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk_state();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Fill with 0x01..0x50, then one idle cycle to observe full
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        // Drain in order; addr_r wraps 79 -> 0
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("addr_r_wrap", int'(addr_r), 0);

        // Hold 40 entries under simultaneous traffic
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0);
        chk("hold40_count", int'(count), 40);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Empty with simultaneous write/read: write wins, udf set
        step(1'b1, 1'b1, 8'hA5, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Full: overflow attempt, simultaneous read/write, then clr
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        step(1'b1, 1'b0, 8'hFF, 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic with occasional flush
        for (int i = 0; i < 1500; i++) begin
            b = 8'($urandom);
            step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45), b,
                 bit'($urandom_range(0, 199) == 0));
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-burst at count 33
        for (int i = 0; i < 33; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        wr_req = 1'b1;
        wr_data = 8'h77;
        rd_req = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rd_vld", int'(rd_vld), 0);
        chk("async_rd_data", int'(rd_data), 0);
        chk("async_wrt_sig", int'(wrt_sig), 0);
        chk_state();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
